// File: rtl/fac8_pkg.sv
// Shared types and sizing helpers for the radix-8 twiddle factor sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fac8_pkg;

    // Twiddle factor applied by the multiplier for each select code
    typedef enum logic [1:0] {
        FAC_UNITY = 2'd0,
        FAC_NEG_J = 2'd1,
        FAC_W8_1  = 2'd2,
        FAC_W8_3  = 2'd3
    } fac_sel_t;

    // Frame tracking state
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Sideband travelling alongside the multiplier data
    typedef struct packed {
        logic valid;
        logic sof;
        logic eof;
    } sb_t;

    // Number of beats in one frame
    function automatic int fac8_beats(input int n_points, input int lanes);
        return n_points / lanes;
    endfunction

    // Width of a counter that indexes every beat of a frame
    function automatic int fac8_cnt_w(input int beats);
        return (beats <= 2) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/fac8_sb_pipe.sv
// Fixed-depth delay line for the {valid, sof, eof} sideband.
// Latency: DEPTH cycles from sb_in to sb_out.
// Backpressure: none; shifts every cycle.
module fac8_sb_pipe
    import fac8_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rstn,
    input  sb_t  sb_in,
    output sb_t  sb_out
);

    sb_t stage [DEPTH];

    // Shift the sideband one stage per cycle; stage 0 takes the new entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= sb_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign sb_out = stage[DEPTH-1];

endmodule

// File: rtl/fac8_sel_ctrl.sv
// Factor-select sequencer and framing sideband for the 16-lane radix-8 twiddle stage.
// Latency: sel is combinational with din; dout_* sideband trails by MUL_LAT cycles.
// Backpressure: none; beats are taken whenever din_valid is high (MUL_LAT must be >= 1).
module fac8_sel_ctrl
    import fac8_pkg::*;
#(
    parameter int N_POINTS   = 512,
    parameter int DATA_WIDTH = 16,
    parameter int SEL_SHIFT  = 2,
    parameter int MUL_LAT    = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       din_valid,
    input  logic       din_sof,
    input  logic       err_clr,
    output logic [1:0] sel,
    output logic       dout_valid,
    output logic       dout_sof,
    output logic       dout_eof,
    output logic       busy,
    output logic       err_sof
);

    localparam int BEATS = fac8_beats(N_POINTS, DATA_WIDTH);
    localparam int CNT_W = fac8_cnt_w(BEATS);
    // Index is widened so the select field always exists even for short frames
    localparam int IDX_W = (CNT_W > SEL_SHIFT + 2) ? CNT_W : SEL_SHIFT + 2;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic             err_q;

    logic             sof_in;
    logic             accept;
    logic             last_beat;
    logic             err_set;
    logic [CNT_W-1:0] idx;
    logic [IDX_W-1:0] idx_ext;
    fac_sel_t         sel_fac;
    sb_t              sb_in;
    sb_t              sb_out;

    // Beat classification: a qualified sof always restarts at beat 0
    always_comb begin
        sof_in    = din_valid & din_sof;
        idx       = sof_in ? '0 : beat_cnt;
        accept    = din_valid & (din_sof | (state == RUN));
        last_beat = accept & (idx == LAST_BEAT);
        err_set   = sof_in & (state == RUN) & (beat_cnt != '0);
    end

    // Factor select straight from the beat index, no register before the multiplier
    always_comb begin
        idx_ext = IDX_W'(idx);
        sel_fac = fac_sel_t'(2'(idx_ext >> SEL_SHIFT));
    end

    assign sel = sel_fac;

    // Frame FSM and beat counter; the wrap after the last beat is explicit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else if (accept) begin
            if (last_beat) begin
                state    <= IDLE;
                beat_cnt <= '0;
            end else begin
                state    <= RUN;
                beat_cnt <= idx + CNT_W'(1);
            end
        end
    end

    // Sticky mid-frame sof flag; a new error wins over a same-cycle clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    // Dropped beats enter the delay line as all-zero entries
    always_comb begin
        sb_in.valid = accept;
        sb_in.sof   = sof_in;
        sb_in.eof   = last_beat;
    end

    fac8_sb_pipe #(
        .DEPTH (MUL_LAT)
    ) u_sb_pipe (
        .clk    (clk),
        .rstn   (rstn),
        .sb_in  (sb_in),
        .sb_out (sb_out)
    );

    assign dout_valid = sb_out.valid;
    assign dout_sof   = sb_out.sof;
    assign dout_eof   = sb_out.eof;
    assign busy       = (state == RUN);
    assign err_sof    = err_q;

endmodule

// File: doc/fac8_sel_ctrl.md
Name: fac8_sel_ctrl

Overview:
- Sequencer for the 16-lane radix-8 twiddle multiplier stage (sel-driven, 1-cycle registered output).
- Tracks beat position inside each streamed FFT frame and drives the 2-bit factor select in the same cycle as the data.
- Produces valid/sof/eof sideband aligned to the multiplier output so the downstream stage sees a framed stream.
- Flags framing errors.

Parameters:
- N_POINTS, 512, FFT frame length in samples.
- DATA_WIDTH, 16, samples per beat (lanes); BEATS = N_POINTS/DATA_WIDTH = 32.
- SEL_SHIFT, 2, sel = beat index bits [SEL_SHIFT+1:SEL_SHIFT].
- MUL_LAT, 1, multiplier latency in cycles; sideband delay. Must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- din_valid  in  1  input beat valid (no backpressure).
- din_sof  in  1  first beat of frame; qualified by din_valid.
- err_clr  in  1  clears err_sof (synchronous pulse).
- sel  out  2  factor select to the multiplier; combinational, same cycle as din.
- dout_valid  out  1  multiplier output beat valid, delayed MUL_LAT.
- dout_sof  out  1  first output beat of frame, delayed MUL_LAT.
- dout_eof  out  1  last output beat (beat BEATS-1), delayed MUL_LAT.
- busy  out  1  high in RUN state.
- err_sof  out  1  sticky: sof arrived mid-frame.

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, beat_cnt=0, all delay stages 0, err_sof=0. sel then reads 0.
- States: IDLE, RUN.
- IDLE:
  - din_valid&din_sof → accept beat 0 and go to RUN, beat_cnt=1.
  - din_valid without sof → beat dropped; no dout_valid; sel=0.
- RUN:
  - Each din_valid beat advances beat_cnt by 1.
  - din_valid low → stall: hold count and state; gaps are legal.
  - Beat BEATS-1 accepted → eof tagged, beat_cnt=0, go to IDLE.
  - A sof on the very next cycle starts a new frame with no bubble.
- Sof in RUN (beat_cnt != 0):
  - err_sof set.
  - The beat is treated as beat 0 of a new frame: beat_cnt=1, stay in RUN.
  - The truncated frame gets no eof.
- Beat index: idx = (din_valid & din_sof) ? 0 : beat_cnt.
- sel = idx[SEL_SHIFT+1:SEL_SHIFT]:
  - Driven purely combinationally from the registered count and din_sof.
  - No register between sel and the multiplier.
  - When din_valid is low, sel is don't-care but is driven from idx.
- Sideband: accepted beats push {valid, sof, eof} into a MUL_LAT-deep shift register.
  - Dropped beats push zeros.
  - Outputs are the last stage, so dout_* is aligned with the multiplier dout.
- err_sof priority: set beats clear when both occur in the same cycle; otherwise err_clr clears it.
- busy = (state==RUN); it reflects the registered state only.
- beat_cnt width = clog2(BEATS). The wrap at BEATS-1 is explicit; no reliance on natural overflow.

Decomposition:
- Package fac8_pkg:
  - enum fac_sel_t: FAC_UNITY=0, FAC_NEG_J=1, FAC_W8_1=2, FAC_W8_3=3.
  - State enum {IDLE, RUN}.
  - Function computing BEATS and count width.
- One sub-module, fac8_sb_pipe: parameterised-depth shift register for {valid, sof, eof}, async active-low reset to 0. The same delay line is reused by later stages.

Test Plan:
1. Reset then one back-to-back frame (sof on beat 0, 32 valid beats).
   - sel = 0×4, 1×4, 2×4, 3×4, 0×4, 1×4, 2×4, 3×4.
   - dout_valid high cycles 1–32 after the first beat; dout_sof on the first, dout_eof on the 32nd.
   - busy falls the cycle after beat 31.
2. Same frame with din_valid low on every other cycle.
   - Identical sel-per-beat sequence; beat_cnt holds across gaps; eof on beat 31 only.
3. Two frames with sof immediately after eof.
   - No bubble; sel returns to 0 on the second sof; two dout_sof and two dout_eof pulses, each 1 cycle after input.
4. din_valid without sof while IDLE for 5 beats, then a valid frame.
   - No dout_valid for the 5 dropped beats; frame processed normally.
5. Sof injected at beat 10 of a frame.
   - err_sof rises next cycle; the sof beat gets sel=0; count restarts; no eof for the truncated frame.
   - err_clr pulse → err_sof=0; err_clr coincident with a new stray sof leaves err_sof=1.
6. rstn asserted mid-frame at beat 20, then released.
   - All outputs go to 0 immediately (asynchronous); state IDLE.
   - A continuing beat without sof is dropped; the next sof starts a frame with sel=0.
